instr_fetch_seq: RTL
====================

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and reset are the only clock and reset ports.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  leave IDLE, begin fetching at word address 0
- stall  in  1  hold PC, IR and valid this cycle
- PCSrc  in  1  branch taken for instruction currently on instr
- Immediate  in  16  branch offset in words, signed, of instruction on instr
- wrap_en  in  1  1 = continue at address 0 after 31, 0 = halt
- mem_data  in  32  combinational read data from inst_mem
- word_address  out  5  fetch address to inst_mem (= PC)
- instr  out  32  registered instruction (IR)
- instr_pc  out  5  word address IR was fetched from
- instr_valid  out  1  instr is a live instruction
- halted  out  1  block is in HALT
- fetch_count  out  6  instructions delivered valid since start, saturating at 63

Function
REQ-003 FSM states SHALL be IDLE, FETCH, HALT; encoding is in the package.
REQ-004 IDLE: word_address=0, instr_valid=0; start=1 moves to FETCH next edge with PC=0.
REQ-005 FETCH, stall=0, no taken branch: on edge IR<=mem_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1 (mod 32).
REQ-006 Fetch latency SHALL be one cycle: word_address=A in cycle n gives instr=mem[A], instr_valid=1 in cycle n+1.
REQ-007 Taken branch = PCSrc & instr_valid & ~stall; target = instr_pc + 1 + Immediate[4:0] (sign-extended, 5-bit wrap, upper bits ignored).
REQ-008 On a taken branch: PC<=target, the word fetched that cycle SHALL be squashed (instr_valid<=0 next cycle), giving exactly one bubble.
REQ-009 PCSrc SHALL be ignored when instr_valid=0.
REQ-010 stall=1 SHALL freeze PC, IR, instr_pc, instr_valid, fetch_count and state; PCSrc is ignored while stalled and must be held by the consumer.
REQ-011 Wrap: sequential PC=31 with wrap_en=0 SHALL capture mem[31] valid and enter HALT; with wrap_en=1 PC becomes 0 and FETCH continues.
REQ-012 A taken branch whose target lies at or below 31 SHALL never trigger HALT; the REQ-011 halt check applies only to sequential increments.
REQ-013 HALT: instr_valid<=0 next edge, halted=1, word_address held at 31; only reset exits.
REQ-014 fetch_count SHALL increment on every edge where instr_valid becomes or stays 1 with a new (non-stalled) instruction, saturating at 63.
REQ-015 start SHALL be ignored outside IDLE.

Reset
REQ-016 reset=1 at an edge SHALL force IDLE, PC=0, IR=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, overriding stall, start and PCSrc.
REQ-017 Reset mid-FETCH or in HALT SHALL give the same state as power-up reset; the in-flight instruction is discarded.

Structure
REQ-018 Package fetch_pkg SHALL hold ADDR_W=5, DATA_W=32, MEM_DEPTH=32, COUNT_W=6 and the FSM state enum.
REQ-019 Branch target and next-PC selection SHALL be one sub-module, next_pc_calc (combinational); all state stays in instr_fetch_seq.

Verification
REQ-020 Bench SHALL drive mem_data from the existing inst_mem model, addressed by word_address, and cover:
- reset, start, no stall/branch, wrap_en=0 -> 32 valid instrs at addresses 0..31, then halted=1, fetch_count=32.
- PCSrc=1, Immediate=16'hFFFD on instr_pc=5 -> one bubble, next valid instr_pc=3.
- stall held 3 cycles at PC=7 -> word_address, instr, instr_valid unchanged for 3 cycles; resumes at instr_pc=7 then 8.
- wrap_en=1, Immediate=16'h0004 at instr_pc=30 -> target 3 (wrap), no HALT, fetch continues.
- reset asserted in HALT and mid-FETCH at PC=12 -> all outputs 0 next cycle, state IDLE, start restarts at address 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, limits, FSM encoding and helpers for the instruction fetch sequencer
package fetch_pkg;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 32;
   localparam int COUNT_W   = 6;

   // Highest word address of the instruction memory; sequential fetch past it wraps or halts
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Increment that sticks at the all-ones value instead of rolling over
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
      return (value == COUNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational branch target and next-PC selection
module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] instr_pc,
   input  logic [ADDR_W-1:0] imm,
   input  logic              taken,
   input  logic              wrap_en,
   output logic [ADDR_W-1:0] next_pc,
   output logic              halt_req
);

   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] seq_pc;

   // Branch target is relative to the instruction after the branch; the low offset bits
   // already act as a sign-extended value once the sum wraps at the address width.
   // The end-of-memory halt only applies to sequential fetch, never to a taken branch.
   always_comb begin
      target   = instr_pc + ADDR_W'(1) + imm;
      seq_pc   = pc + ADDR_W'(1);
      halt_req = 1'b0;
      next_pc  = seq_pc;
      if (taken) begin
         next_pc = target;
      end else if ((pc == LAST_ADDR) && !wrap_en) begin
         halt_req = 1'b1;
         next_pc  = pc;
      end
   end

endmodule

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - single-issue instruction fetch sequencer with branch squash, stall and wrap/halt
module instr_fetch_seq
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stall,
   input  logic               PCSrc,
   input  logic [15:0]        Immediate,
   input  logic               wrap_en,
   input  logic [DATA_W-1:0]  mem_data,
   output logic [ADDR_W-1:0]  word_address,
   output logic [DATA_W-1:0]  instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic               halted,
   output logic [COUNT_W-1:0] fetch_count
);

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W-1:0]   ir;
   logic [ADDR_W-1:0]   ir_pc;
   logic                ir_valid;
   logic                halt_q;
   logic [COUNT_W-1:0]  count_q;

   logic                taken;
   logic [ADDR_W-1:0]   next_pc;
   logic                halt_req;

   // Only the low offset bits matter because the target wraps at the address width
   logic                unused_imm_hi;
   assign unused_imm_hi = ^Immediate[15:ADDR_W];

   // A branch only counts for a live instruction on a non-stalled fetch cycle
   assign taken = PCSrc && ir_valid && !stall && (state == ST_FETCH);

   next_pc_calc u_next_pc (
      .pc       (pc),
      .instr_pc (ir_pc),
      .imm      (Immediate[ADDR_W-1:0]),
      .taken    (taken),
      .wrap_en  (wrap_en),
      .next_pc  (next_pc),
      .halt_req (halt_req)
   );

   // Fetch FSM: owns PC, IR and every status register; stall freezes all of it
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         pc       <= '0;
         ir       <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         halt_q   <= 1'b0;
         count_q  <= '0;
      end else if (!stall) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  pc    <= '0;
               end
            end
            ST_FETCH: begin
               pc <= next_pc;
               if (taken) begin
                  // The word read this cycle is on the wrong path: drop it, one bubble
                  ir_valid <= 1'b0;
               end else begin
                  ir       <= mem_data;
                  ir_pc    <= pc;
                  ir_valid <= 1'b1;
                  count_q  <= sat_inc(count_q);
                  if (halt_req) begin
                     state  <= ST_HALT;
                     halt_q <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               pc       <= LAST_ADDR;
               ir_valid <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign word_address = pc;
   assign instr        = ir;
   assign instr_pc     = ir_pc;
   assign instr_valid  = ir_valid;
   assign halted       = halt_q;
   assign fetch_count  = count_q;

endmodule
